// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: two-flop sync, stability counter, press/release pulses.
// Optional auto-repeat of Press while a key is held is enabled by defining DEBOUNCE_REPEAT_EN.
module debounce_bank #(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 15,
  parameter int ACTIVE_LOW   = 1,
  parameter int RPT_W        = 24,
  parameter int REPEAT_DELAY = 12000000,
  parameter int REPEAT_RATE  = 3000000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Tick,
  input  logic [CHANNELS-1:0] Sw,
  output logic [CHANNELS-1:0] SwState,
  output logic [CHANNELS-1:0] Press,
  output logic [CHANNELS-1:0] Release,
  output logic                AnyEvent
);

  localparam logic [CHANNELS-1:0] IDLE_LEVEL = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CNT_W-1:0]    CNT_MAX    = '1;

  logic [CHANNELS-1:0] sync1_q, sync2_q, raw;
  logic [CHANNELS-1:0] sw_state_q, sw_state_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] release_q, release_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] rpt_fire;

  // Any sample that agrees with the debounced level restarts the stability interval.
  always_comb begin
    raw        = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    sw_state_d = sw_state_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (raw[i] == sw_state_q[i]) begin
        cnt_d[i] = '0;
      end else if (Tick) begin
        if (cnt_q[i] == CNT_MAX) begin
          sw_state_d[i] = raw[i];
          cnt_d[i]      = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    press_d   = (~sw_state_q & sw_state_d) | rpt_fire;
    release_d = sw_state_q & ~sw_state_d;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q    <= IDLE_LEVEL;
      sync2_q    <= IDLE_LEVEL;
      sw_state_q <= '0;
      press_q    <= '0;
      release_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= Sw;
      sync2_q    <= sync1_q;
      sw_state_q <= sw_state_d;
      press_q    <= press_d;
      release_q  <= release_d;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  logic [RPT_W-1:0]    rpt_cnt_q [CHANNELS];
  logic [RPT_W-1:0]    rpt_cnt_d [CHANNELS];
  logic [CHANNELS-1:0] rpt_seen_q, rpt_seen_d;

  // A repeat is suppressed on the edge the key releases, so release never trails a Press.
  always_comb begin
    rpt_fire   = '0;
    rpt_seen_d = rpt_seen_q;
    for (int i = 0; i < CHANNELS; i++) begin
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (!sw_state_q[i] || !sw_state_d[i]) begin
        rpt_cnt_d[i]  = '0;
        rpt_seen_d[i] = 1'b0;
      end else if (Tick) begin
        if (rpt_cnt_q[i] == (rpt_seen_q[i] ? RATE_LAST : DELAY_LAST)) begin
          rpt_fire[i]   = 1'b1;
          rpt_cnt_d[i]  = '0;
          rpt_seen_d[i] = 1'b1;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rpt_seen_q <= '0;
      for (int i = 0; i < CHANNELS; i++) rpt_cnt_q[i] <= '0;
    end else begin
      rpt_seen_q <= rpt_seen_d;
      for (int i = 0; i < CHANNELS; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{RPT_W, REPEAT_DELAY, REPEAT_RATE};
  assign rpt_fire   = '0;
`endif

  assign SwState  = sw_state_q;
  assign Press    = press_q;
  assign Release  = release_q;
  assign AnyEvent = |(press_q | release_q);

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent switch channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 15: stability counter width; required stable time is 2^CNT_W Tick cycles.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 means a raw input of 0 is "pressed"; 0 means a raw input of 1 is "pressed".
REQ-004 SHALL have parameter RPT_W, default 24: auto-repeat counter width.
REQ-005 SHALL have parameter REPEAT_DELAY, default 12000000: Tick cycles from first Press to first repeat.
REQ-006 SHALL have parameter REPEAT_RATE, default 3000000: Tick cycles between subsequent repeats.
REQ-007 Clk  input  1  single clock; all state on its rising edge.
REQ-008 Reset  input  1  synchronous, active-high reset.
REQ-009 Tick  input  1  count enable; counters advance only on cycles where Tick=1.
REQ-010 Sw  input  CHANNELS  raw asynchronous switch inputs.
REQ-011 SwState  output  CHANNELS  debounced level per channel, 1 = pressed.
REQ-012 Press  output  CHANNELS  one-cycle pulse per press event, plus repeat pulses when enabled.
REQ-013 Release  output  CHANNELS  one-cycle pulse per release event.
REQ-014 AnyEvent  output  1  combinational OR of all Press and Release bits.

Function
REQ-015 Each channel SHALL pass Sw through a two-flop synchronizer, then apply the ACTIVE_LOW inversion, producing Raw.
REQ-016 On any cycle where Raw equals SwState, the channel stability counter SHALL clear to 0, regardless of Tick.
REQ-017 On a cycle where Raw differs from SwState and Tick=1:
- if the counter is below 2^CNT_W-1, it SHALL increment by 1;
- if the counter equals 2^CNT_W-1, SwState SHALL take the value of Raw and the counter SHALL clear.
REQ-018 Latency: with Tick held at 1, a clean input change sampled at edge e0 SHALL update SwState at edge e0+1+2^CNT_W.
REQ-019 A single cycle of Raw equal to SwState (a bounce) SHALL restart the full stability interval.
REQ-020 Press[i] SHALL be high for exactly one cycle, registered on the same edge at which SwState[i] goes 0->1.
REQ-021 Release[i] SHALL be high for exactly one cycle, registered on the same edge at which SwState[i] goes 1->0.
REQ-022 Channels SHALL be fully independent; any combination of channels MAY pulse in the same cycle.
REQ-023 The counter SHALL never wrap; the saturation value 2^CNT_W-1 is always consumed by the SwState update.

Reset
REQ-024 While Reset=1, on each edge:
- synchronizer flops SHALL load the not-pressed level;
- all counters SHALL clear;
- SwState, Press and Release SHALL be 0.
REQ-025 Reset SHALL override Tick and any in-progress debounce or repeat, including mid-interval.
REQ-026 After Reset deasserts, a switch held pressed SHALL produce one Press after the full REQ-018 latency.

Configuration
REQ-027 Macro DEBOUNCE_REPEAT_EN SHALL select the auto-repeat feature.
- Defined: while SwState[i]=1, a per-channel RPT_W-bit counter SHALL advance on Tick.
  - Press[i] SHALL re-pulse REPEAT_DELAY ticks after the initial Press, then every REPEAT_RATE ticks.
  - The counter SHALL clear on each pulse and whenever SwState[i]=0.
  - Release SHALL stop repeats with no further Press.
- Undefined: no repeat logic SHALL be synthesized; Press SHALL pulse once per press; RPT_W, REPEAT_DELAY and REPEAT_RATE SHALL be ignored.

Verification (CHANNELS=4, CNT_W=3, ACTIVE_LOW=1, Tick=1 unless stated)
REQ-028 Sw[0] goes 1->0 and is held -> SwState[0]=1 and Press[0]=1 for one cycle exactly 10 edges after the change; AnyEvent=1 in that cycle.
REQ-029 Sw[1] toggles every 5 cycles for 40 cycles, then is held at 0 -> no Press during toggling; a single Press 10 edges after the last change.
REQ-030 Sw[2] and Sw[3] change on the same edge -> Press[2] and Press[3] high in the same cycle; release both -> simultaneous Release pulses.
REQ-031 Tick high every 4th cycle, Sw[0] pressed -> SwState rises after 8 Tick-qualified mismatch cycles (about 32 edges + 2).
REQ-032 Reset asserted for 1 cycle at counter value 5 -> all outputs 0; the held press re-debounces with a full 10-edge latency.
REQ-033 DEBOUNCE_REPEAT_EN, REPEAT_DELAY=20, REPEAT_RATE=5, Sw[0] held 50 cycles -> Press pulses at t, t+20, t+25, t+30, ...; none after release. Without the macro -> a single Press only.
